fifo_ctrl_fwft: RTL and testbench
=================================

Name: fifo_ctrl_fwft

Overview:
- First-word-fall-through (FWFT) FIFO controller for switch port queues.
- Drives the write and read ports of an external dpram_sclk instance: 1-cycle registered read, STATE_KEEP=1, so dout holds its value until the next re.
- Presents a valid/empty + rd_en pop interface to the downstream scheduler and a wr_en/full push interface to the upstream ingress logic.
- The RAM read register is the output register; no extra data register in this block.

Parameters:
- ADDR_WIDTH, 9, RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 16, word width; must match the attached RAM.
- AFULL_THRESH, 2**ADDR_WIDTH-4, almost_full asserts when count >= AFULL_THRESH.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- wr_en, input, 1: push request.
- wr_data, input, DATA_WIDTH: push data.
- full, output, 1: count == DEPTH.
- almost_full, output, 1: count >= AFULL_THRESH.
- rd_en, input, 1: pop the head word; legal only while !empty.
- rd_data, output, DATA_WIDTH: head word; wired to ram_dout; valid while !empty.
- empty, output, 1: no word presented (!out_valid).
- count, output, ADDR_WIDTH+1: words held = ram_cnt + out_valid.
- overflow, output, 1: 1-cycle pulse when wr_en && full.
- underflow, output, 1: 1-cycle pulse when rd_en && empty.
- ram_waddr, output, ADDR_WIDTH: RAM write address (wptr).
- ram_we, output, 1: RAM write enable.
- ram_din, output, DATA_WIDTH: RAM write data (= wr_data).
- ram_raddr, output, ADDR_WIDTH: RAM read address (rptr).
- ram_re, output, 1: RAM read enable.
- ram_dout, input, DATA_WIDTH: RAM read data.

Behaviour:
- State registers: wptr, rptr (ADDR_WIDTH, natural wrap DEPTH-1 -> 0); ram_cnt (ADDR_WIDTH+1, words in RAM not yet prefetched); out_valid (1).
- Reset (rst=1 at posedge): wptr=rptr=0, ram_cnt=0, out_valid=0, overflow=underflow=0.
  - Resulting outputs: empty=1, full=0, almost_full=0 (AFULL_THRESH>0), count=0.
  - RAM contents are not cleared.
  - Reset mid-operation discards all queued words. rd_data is don't-care while empty.
  - Inputs are ignored during the reset cycle.
- Push (combinational):
  - ram_we = wr_en && !full; ram_waddr = wptr; ram_din = wr_data.
  - On ram_we, wptr increments at the edge.
  - wr_en while full: no write, no pointer change, overflow pulses the next cycle (registered).
- Prefetch (combinational):
  - ram_re = (ram_cnt != 0) && (!out_valid || rd_en); ram_raddr = rptr.
  - On ram_re, rptr increments.
- ram_cnt next value = ram_cnt + ram_we - ram_re. Simultaneous push and prefetch leave it unchanged.
- out_valid next value:
  - 1 if ram_re;
  - else 0 if rd_en;
  - else hold.
- Pop:
  - rd_en with !empty consumes rd_data at the edge.
  - The next word appears on the following cycle if ram_cnt was non-zero, giving back-to-back pops at 1 word/cycle.
  - rd_en while empty: ignored, underflow pulses the next cycle.
- Latency:
  - Push at edge t into an empty FIFO gives ram_re in cycle t+1 and !empty with rd_data valid in cycle t+2.
  - Push-to-empty-deassert is 2 cycles.
- Collision: the read address never equals the write address of the same cycle, since the prefetch only reads words written at earlier edges. The block does not depend on the RAM bypass.
- full/count:
  - count includes the prefetched head word.
  - full at count == DEPTH, with no extra skid slot.
  - Push and pop in the same cycle while full: push rejected (full is evaluated pre-edge), pop accepted.
- Simultaneous push and pop with count==1 (head only, ram_cnt=0):
  - head consumed, out_valid goes to 0, new word written;
  - empty holds 1 for exactly one cycle, then the new word appears.

Test Plan:
- Reset then idle: assert rst 2 cycles -> empty=1, full=0, count=0, ram_we=ram_re=0; rd_en=1 one cycle -> underflow=1 next cycle, count stays 0.
- Single word: push 16'hA5A5 at t -> ram_re=1 at t+1; empty=0 and rd_data=16'hA5A5 at t+2; pop -> empty=1, count=0.
- Fill to full (ADDR_WIDTH=3, AFULL_THRESH=4):
  - push 0..7 back-to-back -> almost_full=1 once count=4, full=1 at count=8;
  - 9th push -> overflow pulse, count stays 8;
  - pop 8 -> data 0..7 in order, pointers wrap to 0.
- Streaming: fill 3 words, then wr_en=rd_en=1 for 20 cycles with incrementing data -> rd_data strictly incrementing with no gaps, count constant at 3.
- Push+pop at count==1: head=16'h0001 with a simultaneous push of 16'h0002 -> empty=1 next cycle only, then rd_data=16'h0002.
- Reset mid-stream with count=5 -> next cycle empty=1, count=0; the first push after reset reads back correctly at rptr=0.

Source files
------------

// File: rtl/fifo_ctrl_fwft.sv
// First-word-fall-through FIFO controller driving an external single-clock
// dual-port RAM. The RAM has a 1-cycle registered read port that holds its
// output until the next read enable. That read register is the head-of-queue
// register, so this block keeps only pointers, an occupancy count and a
// head-valid flag.
module fifo_ctrl_fwft #(
    parameter int ADDR_WIDTH   = 9,
    parameter int DATA_WIDTH   = 16,
    parameter int AFULL_THRESH = 2**ADDR_WIDTH - 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  full_o,
    output logic                  almost_full_o,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    output logic [ADDR_WIDTH-1:0] ram_waddr_o,
    output logic                  ram_we_o,
    output logic [DATA_WIDTH-1:0] ram_din_o,
    output logic [ADDR_WIDTH-1:0] ram_raddr_o,
    output logic                  ram_re_o,
    input  logic [DATA_WIDTH-1:0] ram_dout_i
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH+1)'(AFULL_THRESH);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    // Words sitting in RAM that have not yet been prefetched into the read register.
    logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    // The RAM read register currently holds the head word.
    logic                  out_valid_q, out_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  we;
    logic                  re;

    // Push/prefetch decisions and next-state computation.
    always_comb begin
        count = ram_cnt_q + {{ADDR_WIDTH{1'b0}}, out_valid_q};
        full  = (count == DEPTH_C);
        // Inputs are ignored while reset is asserted so no RAM write slips through.
        we    = !rst && wr_en_i && !full;
        // Refill the read register whenever it is empty or being consumed this cycle.
        // Only words written at earlier edges are counted in ram_cnt, so the read
        // address never collides with the same-cycle write address.
        re    = !rst && (ram_cnt_q != '0) && (!out_valid_q || rd_en_i);

        wptr_d = we ? wptr_q + 1'b1 : wptr_q;
        rptr_d = re ? rptr_q + 1'b1 : rptr_q;

        ram_cnt_d = ram_cnt_q;
        case ({we, re})
            2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
            2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
            default: ram_cnt_d = ram_cnt_q;
        endcase

        out_valid_d = out_valid_q;
        if (re) begin
            out_valid_d = 1'b1;
        end else if (rd_en_i) begin
            out_valid_d = 1'b0;
        end

        overflow_d  = wr_en_i && full;
        underflow_d = rd_en_i && !out_valid_q;
    end

    // State registers with synchronous active-high reset; RAM contents are untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            ram_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            ram_cnt_q   <= ram_cnt_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Output mapping.
    always_comb begin
        full_o        = full;
        almost_full_o = (count >= AFULL_C);
        empty_o       = !out_valid_q;
        count_o       = count;
        rd_data_o     = ram_dout_i;
        overflow_o    = overflow_q;
        underflow_o   = underflow_q;
        ram_we_o      = we;
        ram_waddr_o   = wptr_q;
        ram_din_o     = wr_data_i;
        ram_re_o      = re;
        ram_raddr_o   = rptr_q;
    end

endmodule

// File: tb/tb_fifo_ctrl_fwft.sv
module tb_fifo_ctrl_fwft;

    localparam int AW = 3;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          full, almost_full, empty, overflow, underflow;
    logic [DW-1:0] rd_data;
    logic [AW:0]   count;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic          ram_we, ram_re;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    logic [DW-1:0] mem [0:(2**AW)-1];

    int cmps = 0;
    int errs = 0;

    always #5 clk = ~clk;

    // Behavioural dpram_sclk: registered read that holds without re.
    always @(posedge clk) begin
        if (ram_re) ram_dout <= mem[ram_raddr];
        if (ram_we) mem[ram_waddr] <= ram_din;
    end

    fifo_ctrl_fwft #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AFULL_THRESH(4)) dut (
        .clk(clk), .rst(rst),
        .wr_en_i(wr_en), .wr_data_i(wr_data),
        .full_o(full), .almost_full_o(almost_full),
        .rd_en_i(rd_en), .rd_data_o(rd_data),
        .empty_o(empty), .count_o(count),
        .overflow_o(overflow), .underflow_o(underflow),
        .ram_waddr_o(ram_waddr), .ram_we_o(ram_we), .ram_din_o(ram_din),
        .ram_raddr_o(ram_raddr), .ram_re_o(ram_re), .ram_dout_i(ram_dout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        cmps++; if (empty !== 1'b1) begin errs++; $display("FAIL rst_empty got %b exp 1", empty); end
        cmps++; if (full !== 1'b0) begin errs++; $display("FAIL rst_full got %b exp 0", full); end
        cmps++; if (almost_full !== 1'b0) begin errs++; $display("FAIL rst_afull got %b exp 0", almost_full); end
        cmps++; if (count !== 4'd0) begin errs++; $display("FAIL rst_count got %0d exp 0", count); end
        cmps++; if (ram_we !== 1'b0 || ram_re !== 1'b0) begin errs++; $display("FAIL rst_ram_en got we=%b re=%b exp 0/0", ram_we, ram_re); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        cmps++; if (underflow !== 1'b1) begin errs++; $display("FAIL underflow_pulse got %b exp 1", underflow); end
        cmps++; if (count !== 4'd0) begin errs++; $display("FAIL underflow_count got %0d exp 0", count); end
        tick();
        cmps++; if (underflow !== 1'b0) begin errs++; $display("FAIL underflow_clear got %b exp 0", underflow); end
    endtask

    task automatic test_single();
        wr_en = 1'b1; wr_data = 16'hA5A5; #1;
        cmps++; if (ram_we !== 1'b1 || ram_waddr !== 3'd0) begin errs++; $display("FAIL single_we got we=%b addr=%0d exp 1/0", ram_we, ram_waddr); end
        tick(); wr_en = 1'b0; #1;
        cmps++; if (ram_re !== 1'b1 || empty !== 1'b1) begin errs++; $display("FAIL single_t1 got re=%b empty=%b exp 1/1", ram_re, empty); end
        cmps++; if (count !== 4'd1) begin errs++; $display("FAIL single_count_t1 got %0d exp 1", count); end
        tick();
        cmps++; if (empty !== 1'b0 || rd_data !== 16'hA5A5) begin errs++; $display("FAIL single_t2 got empty=%b data=%h exp 0/a5a5", empty, rd_data); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        cmps++; if (empty !== 1'b1 || count !== 4'd0) begin errs++; $display("FAIL single_pop got empty=%b count=%0d exp 1/0", empty, count); end
    endtask

    task automatic test_fill();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = DW'(i); tick();
            cmps++; if (count !== 4'(i+1)) begin errs++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i+1); end
            cmps++; if (almost_full !== (i+1 >= 4)) begin errs++; $display("FAIL fill_afull[%0d] got %b exp %b", i, almost_full, (i+1 >= 4)); end
            cmps++; if (full !== (i+1 == 8)) begin errs++; $display("FAIL fill_full[%0d] got %b exp %b", i, full, (i+1 == 8)); end
        end
        wr_data = 16'h0008; #1;
        cmps++; if (ram_we !== 1'b0) begin errs++; $display("FAIL ovf_we got %b exp 0", ram_we); end
        tick(); wr_en = 1'b0;
        cmps++; if (overflow !== 1'b1 || count !== 4'd8) begin errs++; $display("FAIL ovf_pulse got ovf=%b count=%0d exp 1/8", overflow, count); end
        tick();
        cmps++; if (overflow !== 1'b0) begin errs++; $display("FAIL ovf_clear got %b exp 0", overflow); end
        for (int k = 0; k < 8; k++) begin
            cmps++; if (empty !== 1'b0 || rd_data !== DW'(k)) begin errs++; $display("FAIL drain[%0d] got empty=%b data=%h exp 0/%h", k, empty, rd_data, k); end
            rd_en = 1'b1;
            // First pop while full also attempts a push, which must be rejected.
            wr_en = (k == 0); wr_data = 16'h0099;
            tick();
            if (k == 0) begin
                cmps++; if (overflow !== 1'b1 || count !== 4'd7) begin errs++; $display("FAIL full_pushpop got ovf=%b count=%0d exp 1/7", overflow, count); end
            end
        end
        rd_en = 1'b0; wr_en = 1'b0;
        cmps++; if (empty !== 1'b1 || count !== 4'd0) begin errs++; $display("FAIL drain_end got empty=%b count=%0d exp 1/0", empty, count); end
        cmps++; if (ram_waddr !== 3'd0 || ram_raddr !== 3'd0) begin errs++; $display("FAIL ptr_wrap got w=%0d r=%0d exp 0/0", ram_waddr, ram_raddr); end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 16'h0100 + DW'(i); tick();
        end
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'h0103 + DW'(i); #1;
            cmps++; if (empty !== 1'b0 || rd_data !== 16'h0100 + DW'(i)) begin errs++; $display("FAIL stream_data[%0d] got empty=%b data=%h exp 0/%h", i, empty, rd_data, 16'h0100 + i); end
            cmps++; if (count !== 4'd3) begin errs++; $display("FAIL stream_count[%0d] got %0d exp 3", i, count); end
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1; #1;
            cmps++; if (empty !== 1'b0 || rd_data !== 16'h0114 + DW'(i)) begin errs++; $display("FAIL stream_drain[%0d] got empty=%b data=%h exp 0/%h", i, empty, rd_data, 16'h0114 + i); end
            tick();
        end
        rd_en = 1'b0;
        cmps++; if (empty !== 1'b1 || count !== 4'd0) begin errs++; $display("FAIL stream_end got empty=%b count=%0d exp 1/0", empty, count); end
    endtask

    task automatic test_pushpop_count1();
        wr_en = 1'b1; wr_data = 16'h0001; tick(); wr_en = 1'b0; tick();
        cmps++; if (empty !== 1'b0 || rd_data !== 16'h0001 || count !== 4'd1) begin errs++; $display("FAIL c1_head got empty=%b data=%h count=%0d exp 0/0001/1", empty, rd_data, count); end
        wr_en = 1'b1; wr_data = 16'h0002; rd_en = 1'b1; tick(); wr_en = 1'b0; rd_en = 1'b0; #1;
        cmps++; if (empty !== 1'b1 || count !== 4'd1 || ram_re !== 1'b1) begin errs++; $display("FAIL c1_gap got empty=%b count=%0d re=%b exp 1/1/1", empty, count, ram_re); end
        tick();
        cmps++; if (empty !== 1'b0 || rd_data !== 16'h0002) begin errs++; $display("FAIL c1_next got empty=%b data=%h exp 0/0002", empty, rd_data); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        cmps++; if (empty !== 1'b1) begin errs++; $display("FAIL c1_pop got empty=%b exp 1", empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 16'h0050 + DW'(i); tick();
        end
        wr_en = 1'b0;
        cmps++; if (count !== 4'd5) begin errs++; $display("FAIL mid_count got %0d exp 5", count); end
        rst = 1'b1; wr_en = 1'b1; wr_data = 16'hDEAD; rd_en = 1'b1; #1;
        cmps++; if (ram_we !== 1'b0) begin errs++; $display("FAIL mid_rst_we got %b exp 0", ram_we); end
        tick(); rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; #1;
        cmps++; if (empty !== 1'b1 || count !== 4'd0) begin errs++; $display("FAIL mid_rst got empty=%b count=%0d exp 1/0", empty, count); end
        wr_en = 1'b1; wr_data = 16'hBEEF; #1;
        cmps++; if (ram_waddr !== 3'd0) begin errs++; $display("FAIL mid_waddr got %0d exp 0", ram_waddr); end
        tick(); wr_en = 1'b0; #1;
        cmps++; if (ram_re !== 1'b1 || ram_raddr !== 3'd0) begin errs++; $display("FAIL mid_raddr got re=%b addr=%0d exp 1/0", ram_re, ram_raddr); end
        tick();
        cmps++; if (empty !== 1'b0 || rd_data !== 16'hBEEF) begin errs++; $display("FAIL mid_data got empty=%b data=%h exp 0/beef", empty, rd_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_streaming();
        test_pushpop_count1();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
